// File: rtl/alu_sequencer_if.sv
// rtl/alu_sequencer_if.sv - program load, control and ALU-drive signal bundle for alu_sequencer
interface alu_sequencer_if #(
  parameter int DATA_W = 8
);
  localparam int IW = 4 + 2 * DATA_W;

  // Host side: program loading, run control, accumulator flags
  logic              prog_we;
  logic [3:0]        prog_addr;
  logic [IW-1:0]     prog_data;
  logic              start;
  logic [3:0]        start_pc;
  logic              z_in;
  logic              carry_in;

  // Sequencer side: ALU drive and status
  logic [DATA_W-1:0] A;
  logic [DATA_W-1:0] B;
  logic [3:0]        ALU_Sel;
  logic              load_acc;
  logic [3:0]        pc;
  logic              busy;
  logic              done;

  modport master (
    output prog_we, prog_addr, prog_data, start, start_pc, z_in, carry_in,
    input  A, B, ALU_Sel, load_acc, pc, busy, done
  );

  modport slave (
    input  prog_we, prog_addr, prog_data, start, start_pc, z_in, carry_in,
    output A, B, ALU_Sel, load_acc, pc, busy, done
  );
endinterface

// File: rtl/alu_sequencer.sv
// rtl/alu_sequencer.sv - 16-entry program sequencer driving an external ALU/accumulator
module alu_sequencer #(
  parameter int DATA_W = 8
) (
  input logic            clk,
  input logic            clb,
  alu_sequencer_if.slave bus
);
  localparam int IW = 4 + 2 * DATA_W;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_EXEC  = 2'd2;
  localparam logic [1:0] S_WAIT  = 2'd3;

  localparam logic [3:0] OP_HALT = 4'h0;
  localparam logic [3:0] OP_BC   = 4'hD;
  localparam logic [3:0] OP_JMP  = 4'hE;
  localparam logic [3:0] OP_BZ   = 4'hF;

  logic [1:0]        state;
  logic [IW-1:0]     ir;
  logic [IW-1:0]     mem [16];

  logic [3:0]        op;
  logic [DATA_W-1:0] fa;
  logic [DATA_W-1:0] fb;
  logic [3:0]        target;
  logic [3:0]        pc_inc;

  assign op     = ir[IW-1 -: 4];
  assign fa     = ir[2*DATA_W-1 -: DATA_W];
  assign fb     = ir[DATA_W-1:0];
  assign target = fb[3:0];
  // 4-bit add wraps 15 -> 0 naturally
  assign pc_inc = bus.pc + 4'd1;

  // Program store: host writes only while idle; reset wipes every word to HALT
  always_ff @(posedge clk or negedge clb) begin
    if (!clb) begin
      for (int i = 0; i < 16; i++) begin
        mem[i] <= '0;
      end
    end else if (bus.prog_we && !bus.busy) begin
      mem[bus.prog_addr] <= bus.prog_data;
    end
  end

  // Fetch/execute FSM; load_acc and done default low so each is a single-cycle pulse
  always_ff @(posedge clk or negedge clb) begin
    if (!clb) begin
      state        <= S_IDLE;
      ir           <= '0;
      bus.pc       <= 4'd0;
      bus.A        <= '0;
      bus.B        <= '0;
      bus.ALU_Sel  <= 4'd0;
      bus.load_acc <= 1'b0;
      bus.busy     <= 1'b0;
      bus.done     <= 1'b0;
    end else begin
      bus.load_acc <= 1'b0;
      bus.done     <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            bus.pc   <= bus.start_pc;
            bus.busy <= 1'b1;
            state    <= S_FETCH;
          end
        end
        S_FETCH: begin
          ir    <= mem[bus.pc];
          state <= S_EXEC;
        end
        S_EXEC: begin
          case (op)
            OP_HALT: begin
              bus.done <= 1'b1;
              bus.busy <= 1'b0;
              state    <= S_IDLE;
            end
            OP_JMP: begin
              bus.pc <= target;
              state  <= S_FETCH;
            end
            OP_BZ: begin
              bus.pc <= bus.z_in ? target : pc_inc;
              state  <= S_FETCH;
            end
            OP_BC: begin
              bus.pc <= bus.carry_in ? target : pc_inc;
              state  <= S_FETCH;
            end
            default: begin
              bus.A        <= fa;
              bus.B        <= fb;
              bus.ALU_Sel  <= op;
              bus.load_acc <= 1'b1;
              state        <= S_WAIT;
            end
          endcase
        end
        S_WAIT: begin
          bus.pc <= pc_inc;
          state  <= S_FETCH;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule
